// File: rtl/sha256_uart_framer.sv
// Length-framed command front end between the UART byte cores and a SHA-256 engine.
// Buffers the payload in a byte FIFO and returns the digest as hex ASCII or raw bytes, or a NAK.
module sha256_uart_framer #(
  parameter int unsigned LEN_BYTES    = 2,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned DIGEST_BYTES = 32,
  parameter int unsigned APPEND_NL    = 1,
  parameter int unsigned TIMEOUT_CYC  = 2000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data_i,
  input  logic         rx_valid_i,
  output logic [7:0]   tx_data_o,
  output logic         tx_start_o,
  input  logic         tx_busy_i,
  output logic         hash_start_o,
  output logic [7:0]   hash_data_o,
  output logic         hash_valid_o,
  output logic         hash_last_o,
  input  logic         hash_ready_i,
  input  logic [255:0] hash_out_i,
  input  logic         hash_done_i,
  output logic         busy_o,
  output logic         err_ovf_o,
  output logic         err_tmo_o
);

  localparam int unsigned LW   = 8 * LEN_BYTES;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned NCHR = (APPEND_NL != 0) ? 2 * DIGEST_BYTES + 1 : 2 * DIGEST_BYTES;

  typedef enum logic [2:0] {
    StIdle, StLen, StPayload, StWaitDone, StSend, StSendGap, StNak, StDiscard
  } state_e;

  state_e         state_q, state_d;
  logic           hex_q, hex_d;
  logic [LW-1:0]  len_q, len_d, rx_cnt_q, rx_cnt_d, pop_cnt_q, pop_cnt_d;
  logic [2:0]     lcnt_q, lcnt_d;
  logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]    tmo_q, tmo_d;
  logic [255:0]   digest_q, digest_d;
  logic [6:0]     idx_q, idx_d;
  logic           err_ovf_q, err_ovf_d, err_tmo_q, err_tmo_d, hs_q, hs_d;
  logic [7:0]     mem_q [FIFO_DEPTH];

  logic           push, pop, flush, full, empty, expect_rx, tmo_en, tmo_hit;
  logic [AW:0]    occ;
  logic [LW-1:0]  len_next;
  logic [7:0]     nib_base, byte_base, hex_chr, chr;
  logic [3:0]     nib;
  logic [6:0]     total;

  assign occ       = wr_ptr_q - rd_ptr_q;
  assign empty     = (occ == '0);
  assign full      = (occ == (AW + 1)'(FIFO_DEPTH));
  assign len_next  = (len_q << 8) | LW'(rx_data_i);
  assign expect_rx = (rx_cnt_q != len_q);

  assign hash_valid_o = (state_q == StPayload) && !empty;
  assign hash_data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign hash_last_o  = hash_valid_o && (pop_cnt_q == len_q - LW'(1));
  assign pop          = hash_valid_o && hash_ready_i;

  // Inter-byte timeout only runs while more bytes are still owed by the host.
  assign tmo_en  = (TIMEOUT_CYC != 0) && ((state_q == StLen) ||
                   (((state_q == StPayload) || (state_q == StDiscard)) && expect_rx));
  assign tmo_hit = tmo_en && !rx_valid_i && (tmo_q == 32'(TIMEOUT_CYC - 1));

  assign nib_base  = 8'd252 - 8'({idx_q, 2'b00});
  assign byte_base = 8'd248 - 8'({idx_q, 3'b000});
  assign nib       = digest_q[nib_base +: 4];
  assign hex_chr   = (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h57 + {4'h0, nib};
  assign total     = hex_q ? 7'(NCHR) : 7'(DIGEST_BYTES);
  assign chr       = !hex_q ? digest_q[byte_base +: 8] :
                     (idx_q == 7'(2 * DIGEST_BYTES)) ? 8'h0a : hex_chr;

  assign busy_o       = (state_q != StIdle);
  assign err_ovf_o    = err_ovf_q;
  assign err_tmo_o    = err_tmo_q;
  assign hash_start_o = hs_q;

  always_comb begin
    state_d   = state_q;
    hex_d     = hex_q;
    len_d     = len_q;
    lcnt_d    = lcnt_q;
    rx_cnt_d  = rx_cnt_q;
    pop_cnt_d = pop_cnt_q;
    digest_d  = digest_q;
    idx_d     = idx_q;
    err_ovf_d = err_ovf_q;
    err_tmo_d = err_tmo_q;
    hs_d      = 1'b0;
    push      = 1'b0;
    flush     = 1'b0;
    tx_start_o = 1'b0;
    tx_data_o  = 8'h00;
    tmo_d     = (rx_valid_i || !tmo_en) ? 32'd0 : tmo_q + 32'd1;

    case (state_q)
      StIdle: begin
        if (rx_valid_i && ((rx_data_i == 8'h01) || (rx_data_i == 8'h02))) begin
          hex_d     = (rx_data_i == 8'h01);
          err_ovf_d = 1'b0;
          err_tmo_d = 1'b0;
          len_d     = '0;
          lcnt_d    = '0;
          rx_cnt_d  = '0;
          pop_cnt_d = '0;
          state_d   = StLen;
        end
      end
      StLen: begin
        if (tmo_hit) begin
          err_tmo_d = 1'b1;
          state_d   = StNak;
        end else if (rx_valid_i) begin
          len_d  = len_next;
          lcnt_d = lcnt_q + 3'd1;
          if (lcnt_q == 3'(LEN_BYTES - 1)) begin
            if (len_next == '0) begin
              state_d = StNak;
            end else begin
              hs_d    = 1'b1;
              state_d = StPayload;
            end
          end
        end
      end
      StPayload: begin
        if (pop) begin
          pop_cnt_d = pop_cnt_q + LW'(1);
          if (pop_cnt_q == len_q - LW'(1)) state_d = StWaitDone;
        end
        if (tmo_hit) begin
          err_tmo_d = 1'b1;
          flush     = 1'b1;
          state_d   = StNak;
        end else if (rx_valid_i && expect_rx) begin
          rx_cnt_d = rx_cnt_q + LW'(1);
          if (full && !pop) begin
            err_ovf_d = 1'b1;
            flush     = 1'b1;
            state_d   = (rx_cnt_q + LW'(1) == len_q) ? StNak : StDiscard;
          end else begin
            push = 1'b1;
          end
        end
      end
      StDiscard: begin
        if (tmo_hit) begin
          err_tmo_d = 1'b1;
          state_d   = StNak;
        end else if (rx_valid_i && expect_rx) begin
          rx_cnt_d = rx_cnt_q + LW'(1);
          if (rx_cnt_q + LW'(1) == len_q) state_d = StNak;
        end
      end
      StWaitDone: begin
        if (hash_done_i) begin
          digest_d = hash_out_i;
          idx_d    = '0;
          state_d  = StSend;
        end
      end
      StSend: begin
        if (!tx_busy_i) begin
          if (idx_q == total) begin
            state_d = StIdle;
          end else begin
            tx_start_o = 1'b1;
            tx_data_o  = chr;
            idx_d      = idx_q + 7'd1;
            state_d    = StSendGap;
          end
        end
      end
      StSendGap: state_d = StSend;
      StNak: begin
        if (!tx_busy_i) begin
          tx_start_o = 1'b1;
          tx_data_o  = 8'h15;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    wr_ptr_d = push ? wr_ptr_q + (AW + 1)'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + (AW + 1)'(1) : rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      hex_q     <= 1'b0;
      len_q     <= '0;
      lcnt_q    <= '0;
      rx_cnt_q  <= '0;
      pop_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tmo_q     <= '0;
      digest_q  <= '0;
      idx_q     <= '0;
      err_ovf_q <= 1'b0;
      err_tmo_q <= 1'b0;
      hs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hex_q     <= hex_d;
      len_q     <= len_d;
      lcnt_q    <= lcnt_d;
      rx_cnt_q  <= rx_cnt_d;
      pop_cnt_q <= pop_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      tmo_q     <= tmo_d;
      digest_q  <= digest_d;
      idx_q     <= idx_d;
      err_ovf_q <= err_ovf_d;
      err_tmo_q <= err_tmo_d;
      hs_q      <= hs_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= rx_data_i;
  end

endmodule

// File: tb/tb_sha256_uart_framer.sv
// Directed bench for sha256_uart_framer: engine and UART transmitter are simple behavioural models.
module tb_sha256_uart_framer;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_busy;
  logic         hash_start;
  logic [7:0]   hash_data;
  logic         hash_valid;
  logic         hash_last;
  logic         hash_ready;
  logic [255:0] hash_out;
  logic         hash_done;
  logic         busy, err_ovf, err_tmo;

  localparam logic [255:0] DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  string exp_hex = "ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad";

  int compared = 0;
  int mismatched = 0;

  logic [7:0] txq[$];
  logic [7:0] xq[$];
  int         hs_cnt = 0;
  int         last_cnt = 0;
  logic [7:0] last_byte = 8'h00;
  int         busy_cnt = 0;
  logic [255:0] dig_v;

  sha256_uart_framer #(
    .LEN_BYTES(2), .FIFO_DEPTH(16), .DIGEST_BYTES(32), .APPEND_NL(1), .TIMEOUT_CYC(1000)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .tx_data_o(tx_data), .tx_start_o(tx_start), .tx_busy_i(tx_busy),
    .hash_start_o(hash_start), .hash_data_o(hash_data), .hash_valid_o(hash_valid),
    .hash_last_o(hash_last), .hash_ready_i(hash_ready), .hash_out_i(hash_out),
    .hash_done_i(hash_done), .busy_o(busy), .err_ovf_o(err_ovf), .err_tmo_o(err_tmo)
  );

  always #5 clk = ~clk;

  assign tx_busy = (busy_cnt != 0);

  // Observers: log engine transfers and transmitted bytes; model a 3-cycle UART.
  always @(posedge clk) begin
    if (hash_start) hs_cnt <= hs_cnt + 1;
    if (hash_valid && hash_ready) begin
      xq.push_back(hash_data);
      if (hash_last) begin
        last_cnt  <= last_cnt + 1;
        last_byte <= hash_data;
      end
    end
    if (tx_start) begin
      txq.push_back(tx_data);
      busy_cnt <= 3;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  bit rnd_ready = 1'b0;

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    if (rnd_ready) hash_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    rx_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (rnd_ready) hash_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  task automatic send_abc(input logic [7:0] cmd);
    send_byte(cmd);
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h61);
    send_byte(8'h62);
    send_byte(8'h63);
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 5000 && txq.size() < n; i++) @(negedge clk);
  endtask

  task automatic wait_last(input int n);
    for (int i = 0; i < 2000 && last_cnt < n; i++) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
  endtask

  task automatic pulse_done();
    hash_done = 1'b1;
    @(negedge clk);
    hash_done = 1'b0;
  endtask

  task automatic check_hex(input string tag, input int base);
    int bad;
    bad = 0;
    check({tag, "_len"}, 64'(txq.size() - base), 64'd65);
    if (txq.size() >= base + 65) begin
      for (int i = 0; i < 64; i++) if (txq[base + i] !== exp_hex[i]) bad++;
      check({tag, "_chars_bad"}, 64'(bad), 64'd0);
      check({tag, "_nl"}, 64'(txq[base + 64]), 64'h0a);
    end
  endtask

  initial begin
    int tb_base, xb, hb, lb, bad, n;
    rst = 1'b1;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    hash_ready = 1'b1;
    hash_out = DIG;
    hash_done = 1'b0;
    dig_v = DIG;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tx_start", 64'(tx_start), 64'd0);
    check("rst_hash_start", 64'(hash_start), 64'd0);
    check("rst_hash_valid", 64'(hash_valid), 64'd0);
    check("rst_errs", 64'({err_ovf, err_tmo}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Hex "abc"
    tb_base = txq.size(); xb = xq.size(); hb = hs_cnt; lb = last_cnt;
    send_abc(8'h01);
    wait_last(lb + 1);
    check("hex_hash_start", 64'(hs_cnt - hb), 64'd1);
    check("hex_xfers", 64'(xq.size() - xb), 64'd3);
    if (xq.size() >= xb + 3)
      check("hex_payload", 64'({xq[xb], xq[xb + 1], xq[xb + 2]}), 64'h616263);
    check("hex_last_byte", 64'(last_byte), 64'h63);
    pulse_done();
    wait_tx(tb_base + 65);
    check_hex("hex", tb_base);
    wait_idle();
    check("hex_idle", 64'(busy), 64'd0);

    // Raw "abc"
    tb_base = txq.size(); lb = last_cnt;
    send_abc(8'h02);
    wait_last(lb + 1);
    pulse_done();
    wait_tx(tb_base + 32);
    wait_idle();
    check("raw_len", 64'(txq.size() - tb_base), 64'd32);
    bad = 0;
    if (txq.size() >= tb_base + 32)
      for (int i = 0; i < 32; i++) if (txq[tb_base + i] !== dig_v[255 - 8 * i -: 8]) bad++;
    check("raw_bytes_bad", 64'(bad), 64'd0);

    // Binary-safe payload
    tb_base = txq.size(); xb = xq.size(); lb = last_cnt;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h02); send_byte(8'hff); send_byte(8'h01);
    wait_last(lb + 1);
    check("bin_xfers", 64'(xq.size() - xb), 64'd2);
    if (xq.size() >= xb + 2) check("bin_payload", 64'({xq[xb], xq[xb + 1]}), 64'hff01);
    check("bin_last_byte", 64'(last_byte), 64'h01);
    pulse_done();
    wait_tx(tb_base + 65);
    wait_idle();

    // Empty frame
    tb_base = txq.size(); hb = hs_cnt;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    wait_tx(tb_base + 1);
    wait_idle();
    repeat (5) @(negedge clk);
    check("empty_tx_count", 64'(txq.size() - tb_base), 64'd1);
    if (txq.size() > tb_base) check("empty_nak", 64'(txq[tb_base]), 64'h15);
    check("empty_no_hash_start", 64'(hs_cnt - hb), 64'd0);

    // Overflow
    hash_ready = 1'b0;
    tb_base = txq.size(); xb = xq.size(); lb = last_cnt;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h14);
    for (int i = 0; i < 20; i++) send_byte(8'(8'h30 + i));
    wait_tx(tb_base + 1);
    wait_idle();
    repeat (5) @(negedge clk);
    check("ovf_err", 64'(err_ovf), 64'd1);
    check("ovf_no_last", 64'(last_cnt - lb), 64'd0);
    check("ovf_no_xfer", 64'(xq.size() - xb), 64'd0);
    check("ovf_tx_count", 64'(txq.size() - tb_base), 64'd1);
    if (txq.size() > tb_base) check("ovf_nak", 64'(txq[tb_base]), 64'h15);
    check("ovf_busy", 64'(busy), 64'd0);
    check("ovf_hash_valid", 64'(hash_valid), 64'd0);
    hash_ready = 1'b1;

    // Timeout, then a good frame clears err_tmo
    tb_base = txq.size();
    send_byte(8'h01);
    check("tmo_cmd_clears_ovf", 64'(err_ovf), 64'd0);
    send_byte(8'h00); send_byte(8'h05); send_byte(8'h61); send_byte(8'h62);
    n = 0;
    while (n < 1200 && !err_tmo) begin
      @(negedge clk);
      n++;
    end
    check("tmo_err", 64'(err_tmo), 64'd1);
    check("tmo_window", 64'((n >= 990) && (n <= 1001)), 64'd1);
    wait_tx(tb_base + 1);
    wait_idle();
    if (txq.size() > tb_base) check("tmo_nak", 64'(txq[tb_base]), 64'h15);
    tb_base = txq.size(); lb = last_cnt;
    send_byte(8'h01);
    check("tmo_cleared", 64'(err_tmo), 64'd0);
    send_byte(8'h00); send_byte(8'h03); send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
    wait_last(lb + 1);
    pulse_done();
    wait_tx(tb_base + 65);
    check_hex("after_tmo", tb_base);
    wait_idle();

    // Random backpressure on a 40-byte payload
    tb_base = txq.size(); xb = xq.size(); lb = last_cnt;
    rnd_ready = 1'b1;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'd40);
    for (int i = 0; i < 40; i++) send_byte(8'(i * 7 + 3));
    rnd_ready = 1'b0;
    hash_ready = 1'b1;
    wait_last(lb + 1);
    check("bp_xfers", 64'(xq.size() - xb), 64'd40);
    bad = 0;
    if (xq.size() >= xb + 40)
      for (int i = 0; i < 40; i++) if (xq[xb + i] !== 8'(i * 7 + 3)) bad++;
    check("bp_order_bad", 64'(bad), 64'd0);
    check("bp_last_byte", 64'(last_byte), 64'(8'(39 * 7 + 3)));
    check("bp_no_ovf", 64'(err_ovf), 64'd0);
    pulse_done();
    wait_tx(tb_base + 65);
    wait_idle();

    // Reset in the middle of SEND, then a clean frame
    tb_base = txq.size(); lb = last_cnt;
    send_abc(8'h01);
    wait_last(lb + 1);
    pulse_done();
    wait_tx(tb_base + 5);
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_tx_start", 64'(tx_start), 64'd0);
    check("midrst_hash", 64'({hash_start, hash_valid, hash_last}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    tb_base = txq.size(); lb = last_cnt;
    send_abc(8'h01);
    wait_last(lb + 1);
    pulse_done();
    wait_tx(tb_base + 65);
    check_hex("post_rst", tb_base);
    wait_idle();
    check("post_rst_idle", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
